seq_shifter: RTL and testbench

SEQ_SHIFTER -- requirements
Module: seq_shifter

---
 rtl/seq_shifter_pkg.sv | 21 ++
 rtl/seq_shifter_shift_step.sv | 34 +++
 rtl/seq_shifter.sv | 110 +++++++++++
 tb/tb_seq_shifter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seq_shifter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_shifter_pkg
//  Description : Shared operation and FSM state encodings for seq_shifter.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_shifter_pkg;

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : seq_shifter_pkg
`default_nettype wire

// File: rtl/seq_shifter_shift_step.sv
`default_nettype none
// ============================================================================
//  Module      : shift_step
//  Description : Combinational single-bit shift/rotate step with carry-out.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_step
    import seq_shifter_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] i_data,
    input  logic [1:0]   i_mode,
    output logic [W-1:0] o_data,
    output logic         o_bit
);

    always_comb begin
        o_data = i_data;
        o_bit  = i_data[0];
        case (i_mode)
            MODE_LSL: begin
                o_data = {i_data[W-2:0], 1'b0};
                o_bit  = i_data[W-1];
            end
            MODE_LSR: o_data = {1'b0, i_data[W-1:1]};
            MODE_ASR: o_data = {i_data[W-1], i_data[W-1:1]};
            MODE_ROR: o_data = {i_data[0], i_data[W-1:1]};
            default:  o_data = i_data;
        endcase
    end

endmodule : shift_step
`default_nettype wire

// File: rtl/seq_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : seq_shifter
//  Description : Multi-cycle shifter, one bit per cycle, LSL/LSR/ASR/ROR.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  din,
    input  logic [CW-1:0] amt,
    input  logic [1:0]    mode,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  dout,
    output logic          c_out,
    output logic          z,
    output logic          n
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_dout;
    logic           r_cout;
    logic [CW-1:0]  r_cnt;
    logic [1:0]     r_mode;
    logic [W-1:0]   w_step_data;
    logic           w_step_bit;
    logic           w_last_step;

    shift_step #(.W(W)) u_step (
        .i_data (r_dout),
        .i_mode (r_mode),
        .o_data (w_step_data),
        .o_bit  (w_step_bit)
    );

    // A zero count in SHIFT cannot occur normally; treat it as final so the FSM never stalls.
    assign w_last_step = (r_cnt == CW'(1)) || (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (amt != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (w_last_step) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= '0;
            r_cout <= 1'b0;
            r_cnt  <= '0;
            r_mode <= MODE_LSL;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_dout <= din;
                        r_cnt  <= amt;
                        r_mode <= mode;
                        r_cout <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    r_dout <= w_step_data;
                    r_cout <= w_step_bit;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy  = (r_state == ST_SHIFT);
    assign done  = (r_state == ST_DONE);
    assign dout  = r_dout;
    assign c_out = r_cout;
    assign z     = (r_dout == '0);
    assign n     = r_dout[W-1];

endmodule : seq_shifter
`default_nettype wire

// File: tb/tb_seq_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_shifter
//  Description : Self-checking bench for seq_shifter (W=8) with reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_shifter;

    localparam int W  = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  din = '0;
    logic [CW-1:0] amt = '0;
    logic [1:0]    mode = 2'b00;
    logic          busy, done, c_out, z, n;
    logic [W-1:0]  dout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    seq_shifter #(.W(W), .CW(CW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .din   (din),
        .amt   (amt),
        .mode  (mode),
        .busy  (busy),
        .done  (done),
        .dout  (dout),
        .c_out (c_out),
        .z     (z),
        .n     (n)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Whole-operation result from plain arithmetic on the operands.
    task automatic model_result(input logic [1:0] md, input logic [W-1:0] d, input logic [CW-1:0] a,
                                output logic [W-1:0] res, output logic c);
        int k;
        logic signed [W-1:0] s;
        k = int'(a);
        s = d;
        res = d;
        c = 1'b0;
        if (k != 0) begin
            case (md)
                2'b00: begin res = d << k; c = d[W-k]; end
                2'b01: begin res = d >> k; c = d[k-1]; end
                2'b10: begin res = s >>> k; c = d[k-1]; end
                default: begin res = (d >> k) | (d << (W-k)); c = d[k-1]; end
            endcase
        end
    endtask

    int          m_left  = 0;
    logic        m_done  = 1'b0;
    logic        m_valid = 1'b0;
    logic [W-1:0] m_dout = '0;
    logic        m_c     = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_left = 0; m_done = 1'b0; m_dout = '0; m_c = 1'b0; m_valid = 1'b1;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_left != 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_valid = 1'b1;
            end
        end else if (start) begin
            model_result(mode, din, amt, m_dout, m_c);
            m_left  = int'(amt);
            m_done  = (amt == '0);
            m_valid = (amt == '0);
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("model busy", {31'd0, busy}, {31'd0, (m_left != 0)});
            check("model done", {31'd0, done}, {31'd0, m_done});
            if (m_valid) begin
                check("model dout", {24'd0, dout}, {24'd0, m_dout});
                check("model c_out", {31'd0, c_out}, {31'd0, m_c});
                check("model z", {31'd0, z}, {31'd0, (m_dout == '0)});
                check("model n", {31'd0, n}, {31'd0, m_dout[W-1]});
            end
        end
    end

    // Drives one operation and checks literal expectations; optionally pokes start while busy.
    task automatic run_op(input logic [1:0] md, input logic [W-1:0] d, input logic [CW-1:0] a,
                          input logic [W-1:0] exp_dout, input logic exp_c, input int exp_lat,
                          input bit poke);
        int lat;
        int nb;
        lat = -1;
        nb  = 0;
        @(negedge clk);
        start = 1'b1; mode = md; din = d; amt = a;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (poke && k == 3) begin
                start = 1'b1; mode = 2'b11; din = 8'hFF; amt = 3'd1;
            end
            if (busy) nb++;
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        check("latency", lat, exp_lat);
        check("busy cycles", nb, exp_lat - 1);
        check("dout", {24'd0, dout}, {24'd0, exp_dout});
        check("c_out", {31'd0, c_out}, {31'd0, exp_c});
        check("z", {31'd0, z}, {31'd0, (exp_dout == 8'h00)});
        check("n", {31'd0, n}, {31'd0, exp_dout[7]});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset dout", {24'd0, dout}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset c_out", {31'd0, c_out}, 32'd0);
        rst = 1'b0;

        run_op(2'b00, 8'b1001_0110, 3'd3, 8'b1011_0000, 1'b0, 4, 1'b0);
        run_op(2'b10, 8'h80, 3'd7, 8'hFF, 1'b0, 8, 1'b0);
        run_op(2'b11, 8'h01, 3'd1, 8'h80, 1'b1, 2, 1'b0);
        run_op(2'b01, 8'h01, 3'd1, 8'h00, 1'b1, 2, 1'b0);
        for (int m = 0; m < 4; m++) begin
            run_op(2'(m), 8'h5A, 3'd0, 8'h5A, 1'b0, 1, 1'b0);
        end
        run_op(2'b11, 8'hB4, 3'd3, 8'h96, 1'b1, 4, 1'b0);
        run_op(2'b01, 8'hB4, 3'd4, 8'h0B, 1'b0, 5, 1'b0);
        run_op(2'b10, 8'h40, 3'd2, 8'h10, 1'b0, 3, 1'b0);
        run_op(2'b00, 8'h81, 3'd1, 8'h02, 1'b1, 2, 1'b0);
        run_op(2'b00, 8'h03, 3'd7, 8'h80, 1'b1, 8, 1'b1);

        // Idle gap: result must hold.
        repeat (3) @(negedge clk);
        check("hold dout", {24'd0, dout}, 32'h80);
        check("hold c_out", {31'd0, c_out}, 32'd1);

        // Reset mid-operation, landing on the third edge after acceptance.
        @(negedge clk);
        start = 1'b1; mode = 2'b00; din = 8'h03; amt = 3'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst dout", {24'd0, dout}, 32'd0);
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        run_op(2'b00, 8'h01, 3'd7, 8'h80, 1'b0, 8, 1'b0);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; mode = 2'b01; din = 8'hF0; amt = 3'd2;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst prio busy", {31'd0, busy}, 32'd0);
        check("rst prio done", {31'd0, done}, 32'd0);
        check("rst prio dout", {24'd0, dout}, 32'd0);
        @(negedge clk);
        check("rst prio idle", {31'd0, busy | done}, 32'd0);

        run_op(2'b11, 8'hC3, 3'd4, 8'h3C, 1'b0, 5, 1'b0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_seq_shifter
`default_nettype wire
